// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: shared defaults, depth constant and controller state type for mem_responder.
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 4;
  localparam int DATA_W_DEFAULT = 8;
  localparam int DEPTH          = 2 ** ADDR_W_DEFAULT;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// mem_array: 2**ADDR_W x DATA_W storage, one synchronous write port, one asynchronous read port, no reset.
module mem_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// mem_responder: zero-fills the array after reset, then serves 1-cycle-latency reads and writes.
// MEM_RDW_NEW_EN: when defined, a simultaneous read+write returns the new data instead of the old word.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_enable,
  input  logic              rd_enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              req_err
);

  localparam int                DEPTH_L   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_L - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              req_err_q, req_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (addr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    busy_d     = busy_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    req_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = data_in;

    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      req_err_d = wr_enable | rd_enable;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    end else begin
      mem_we = wr_enable;
      if (rd_enable) begin
        rd_valid_d = 1'b1;
`ifdef MEM_RDW_NEW_EN
        data_out_d = wr_enable ? data_in : mem_rdata;
`else
        // Async read port still shows the pre-edge word during a same-cycle write.
        data_out_d = mem_rdata;
`endif
      end
    end

    // The array has no reset of its own, so block all writes while reset is held.
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      req_err_q  <= req_err_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign req_err  = req_err_q;

endmodule
`default_nettype wire
